usbfs_tx_sched: RTL and testbench



---
 rtl/usbfs_tx_sched.sv | 116 +++++++++++
 tb/tb_usbfs_tx_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_tx_sched.sv
// USB full-speed IN transmit scheduler: picks the addressed endpoint on an IN token,
// decides DATA/NAK/STALL, routes that endpoint's buffer writes and keeps DATA0/1 toggles.
module usbfs_tx_sched #(
    parameter int N_ENDP  = 4,
    parameter int MAX_PKT = 8,
    localparam int IDX_W  = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_busReset,
    input  logic                  i_inToken,
    input  logic [3:0]            i_inEndp,
    output logic                  o_respValid,
    output logic [1:0]            o_respKind,
    output logic                  o_dataPid,
    input  logic                  i_txAccepted,
    input  logic                  i_hsAck,
    input  logic                  i_hsTimeout,
    output logic                  o_wrEn,
    output logic [IDX_W-1:0]      o_wrIdx,
    output logic [7:0]            o_wrByte,
    input  logic [N_ENDP-1:0]     i_epValid,
    input  logic [N_ENDP-1:0]     i_epStall,
    output logic [N_ENDP-1:0]     o_epReady,
    output logic [N_ENDP-1:0]     o_epTxAccepted,
    input  logic [N_ENDP-1:0]     i_epWrEn,
    input  logic [N_ENDP*IDX_W-1:0] i_epWrIdx,
    input  logic [N_ENDP*8-1:0]   i_epWrByte,
    input  logic [N_ENDP-1:0]     i_toggleClr
);

    localparam logic [1:0] KIND_DATA  = 2'd0;
    localparam logic [1:0] KIND_NAK   = 2'd1;
    localparam logic [1:0] KIND_STALL = 2'd2;

    typedef enum logic [1:0] {IDLE, RESP, DATA} state_t;

    state_t            state;
    logic [3:0]        sel_q;
    logic [N_ENDP-1:0] toggle;
    logic [N_ENDP-1:0] toggle_next;
    logic [15:0]       valid_x, stall_x, toggle_x;
    logic              sel_ok;
    logic              reset_any;
    logic [1:0]        kind;

    assign reset_any = i_rst | i_busReset;

    // Pad per-endpoint vectors to the full 4-bit endpoint space so any token number indexes safely.
    always_comb begin
        valid_x  = '0;
        stall_x  = '0;
        toggle_x = '0;
        valid_x[N_ENDP-1:0]  = i_epValid;
        stall_x[N_ENDP-1:0]  = i_epStall;
        toggle_x[N_ENDP-1:0] = toggle;
        sel_ok = int'(sel_q) < N_ENDP;
        if (!sel_ok || stall_x[sel_q])
            kind = KIND_STALL;
        else if (valid_x[sel_q])
            kind = KIND_DATA;
        else
            kind = KIND_NAK;
    end

    // A clear applies after the ACK flip so it always wins.
    always_comb begin
        toggle_next = toggle;
        for (int k = 0; k < N_ENDP; k++)
            if (state == DATA && i_hsAck && sel_q == 4'(k))
                toggle_next[k] = ~toggle[k];
        toggle_next = toggle_next & ~i_toggleClr;
    end

    always_ff @(posedge i_clk) begin
        if (reset_any) begin
            state  <= IDLE;
            sel_q  <= '0;
            toggle <= '0;
        end else begin
            toggle <= toggle_next;
            case (state)
                IDLE: if (i_inToken) begin
                    sel_q <= i_inEndp;
                    state <= RESP;
                end
                RESP: state <= (kind == KIND_DATA) ? DATA : IDLE;
                DATA: if (i_hsAck || i_hsTimeout) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_respValid    = (state == RESP);
        o_respKind     = (state == RESP) ? kind : KIND_DATA;
        o_dataPid      = (state != IDLE) && toggle_x[sel_q];
        o_wrEn         = 1'b0;
        o_wrIdx        = '0;
        o_wrByte       = '0;
        o_epReady      = '0;
        o_epTxAccepted = '0;
        for (int k = 0; k < N_ENDP; k++) begin
            if (sel_q == 4'(k)) begin
                o_wrIdx  = i_epWrIdx[k*IDX_W +: IDX_W];
                o_wrByte = i_epWrByte[k*8 +: 8];
                if (state == DATA) begin
                    o_wrEn            = i_epWrEn[k];
                    o_epTxAccepted[k] = i_txAccepted;
                    o_epReady[k]      = i_hsAck && !reset_any;
                end
            end
        end
    end

endmodule

// File: tb/tb_usbfs_tx_sched.sv
// Bench for usbfs_tx_sched: response table, hand-written corner sequences and a
// randomized transaction-level model of toggles and routing.
module tb_usbfs_tx_sched;

    localparam int NE = 4;
    localparam int IW = 3;

    logic          i_clk = 0;
    logic          i_rst, i_busReset, i_inToken, i_txAccepted, i_hsAck, i_hsTimeout;
    logic [3:0]    i_inEndp;
    logic          o_respValid, o_dataPid, o_wrEn;
    logic [1:0]    o_respKind;
    logic [IW-1:0] o_wrIdx;
    logic [7:0]    o_wrByte;
    logic [NE-1:0] i_epValid, i_epStall, o_epReady, o_epTxAccepted, i_epWrEn, i_toggleClr;
    logic [NE*IW-1:0] i_epWrIdx;
    logic [NE*8-1:0]  i_epWrByte;

    int errors = 0;
    int checks = 0;

    usbfs_tx_sched #(.N_ENDP(NE), .MAX_PKT(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_busReset(i_busReset),
        .i_inToken(i_inToken), .i_inEndp(i_inEndp),
        .o_respValid(o_respValid), .o_respKind(o_respKind), .o_dataPid(o_dataPid),
        .i_txAccepted(i_txAccepted), .i_hsAck(i_hsAck), .i_hsTimeout(i_hsTimeout),
        .o_wrEn(o_wrEn), .o_wrIdx(o_wrIdx), .o_wrByte(o_wrByte),
        .i_epValid(i_epValid), .i_epStall(i_epStall), .o_epReady(o_epReady),
        .o_epTxAccepted(o_epTxAccepted), .i_epWrEn(i_epWrEn), .i_epWrIdx(i_epWrIdx),
        .i_epWrByte(i_epWrByte), .i_toggleClr(i_toggleClr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle, then drop all single-cycle strobes.
    task automatic cyc();
        @(posedge i_clk);
        #1;
        i_inToken = 0; i_hsAck = 0; i_hsTimeout = 0; i_txAccepted = 0;
        i_toggleClr = 0; i_busReset = 0; i_rst = 0; i_epWrEn = 0;
    endtask

    task automatic tok(input int e);
        i_inToken = 1;
        i_inEndp  = 4'(e);
        cyc();
    endtask

    task automatic resp(input string name, input int kind, input int pid);
        @(negedge i_clk);
        chk({name, ".valid"}, o_respValid, 1);
        chk({name, ".kind"}, o_respKind, kind);
        if (pid >= 0) chk({name, ".pid"}, o_dataPid, pid);
        cyc();
    endtask

    // Close a DATA phase with a handshake and check the ready pulse.
    task automatic hs(input string name, input bit ack, input bit to, input int ready);
        i_hsAck = ack;
        i_hsTimeout = to;
        @(negedge i_clk);
        chk({name, ".ready"}, o_epReady, ready);
        cyc();
    endtask

    typedef struct {
        int       endp;
        bit [3:0] valid;
        bit [3:0] stall;
        int       kind;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit [3:0] mtog;
        i_rst = 1; i_busReset = 0; i_inToken = 0; i_inEndp = 0;
        i_txAccepted = 0; i_hsAck = 0; i_hsTimeout = 0;
        i_epValid = 0; i_epStall = 0; i_epWrEn = 0; i_epWrIdx = 0; i_epWrByte = 0;
        i_toggleClr = 0;
        cyc();

        // Reset state, with strobes asserted that must stay blocked in IDLE.
        i_epWrEn = '1; i_txAccepted = 1;
        @(negedge i_clk);
        chk("rst.respValid", o_respValid, 0);
        chk("rst.kind", o_respKind, 0);
        chk("rst.pid", o_dataPid, 0);
        chk("rst.wrEn", o_wrEn, 0);
        chk("rst.epReady", o_epReady, 0);
        chk("rst.epTxAcc", o_epTxAccepted, 0);
        cyc();

        vecs[0] = '{1, 4'b0000, 4'b0000, 1};
        vecs[1] = '{1, 4'b0010, 4'b0010, 2};
        vecs[2] = '{7, 4'b1111, 4'b0000, 2};
        vecs[3] = '{2, 4'b0100, 4'b0000, 0};
        vecs[4] = '{0, 4'b1111, 4'b0001, 2};
        vecs[5] = '{3, 4'b1000, 4'b0000, 0};
        vecs[6] = '{15, 4'b1111, 4'b1111, 2};
        vecs[7] = '{2, 4'b1011, 4'b0000, 1};
        for (int i = 0; i < 8; i++) begin
            i_epValid = vecs[i].valid;
            i_epStall = vecs[i].stall;
            tok(vecs[i].endp);
            resp($sformatf("vec%0d", i), vecs[i].kind, 0);
            if (vecs[i].kind == 0) begin
                hs($sformatf("vec%0d.to", i), 0, 1, 0);
            end else begin
                i_epWrEn = '1;
                @(negedge i_clk);
                chk($sformatf("vec%0d.idle_wrEn", i), o_wrEn, 0);
                chk($sformatf("vec%0d.idle_resp", i), o_respValid, 0);
                cyc();
            end
        end
        i_epStall = 0;

        // DATA then ACK on endpoint 2, with writes routed through.
        i_epValid = 4'b0100;
        tok(2);
        resp("ack2", 0, 0);
        i_txAccepted = 1;
        @(negedge i_clk);
        chk("ack2.txAcc", o_epTxAccepted, 4'b0100);
        cyc();
        for (int i = 0; i < 3; i++) begin
            i_epWrEn = 4'b0100;
            i_epWrIdx = 12'($urandom);
            i_epWrByte = $urandom;
            i_epWrIdx[2*IW +: IW] = 3'(i);
            i_epWrByte[16 +: 8] = 8'(8'hA0 + i);
            @(negedge i_clk);
            chk("ack2.wrEn", o_wrEn, 1);
            chk("ack2.wrIdx", o_wrIdx, i);
            chk("ack2.wrByte", o_wrByte, 8'hA0 + i);
            cyc();
        end
        hs("ack2", 1, 0, 4'b0100);
        tok(2);
        resp("ack2.retry", 0, 1);
        hs("ack2.retry", 0, 1, 0);

        // Timeout keeps toggle; ACK+timeout behaves as ACK; clear beats same-cycle flip.
        i_epValid = 4'b0001;
        tok(0);
        resp("to0", 0, 0);
        hs("to0", 0, 1, 0);
        tok(0);
        resp("to0.retry", 0, 0);
        hs("both0", 1, 1, 4'b0001);
        tok(0);
        resp("both0.next", 0, 1);
        hs("both0.next", 0, 1, 0);
        i_toggleClr = 4'b0001;
        cyc();
        tok(0);
        resp("clr0", 0, 0);
        i_toggleClr = 4'b0001;
        hs("clr0", 1, 0, 4'b0001);
        tok(0);
        resp("clr0.next", 0, 0);
        hs("clr0.next", 0, 1, 0);

        // Token during DATA is ignored and other endpoints cannot write.
        i_epValid = 4'b1010;
        tok(1);
        resp("busy1", 0, 0);
        i_inToken = 1; i_inEndp = 3; i_epWrEn = 4'b1000;
        @(negedge i_clk);
        chk("busy1.wrEn_ep3", o_wrEn, 0);
        cyc();
        i_epWrEn = 4'b1000;
        @(negedge i_clk);
        chk("busy1.noresp", o_respValid, 0);
        chk("busy1.wrEn_ep3b", o_wrEn, 0);
        cyc();
        i_epWrEn = 4'b0010;
        @(negedge i_clk);
        chk("busy1.wrEn_ep1", o_wrEn, 1);
        cyc();
        hs("busy1", 1, 0, 4'b0010);

        // Bus reset mid-transaction with toggle[1]=1 and toggle[2]=1.
        tok(1);
        resp("br1", 0, 1);
        i_busReset = 1;
        hs("br1", 1, 0, 0);
        i_epWrEn = '1; i_txAccepted = 1;
        @(negedge i_clk);
        chk("br1.respValid", o_respValid, 0);
        chk("br1.wrEn", o_wrEn, 0);
        chk("br1.txAcc", o_epTxAccepted, 0);
        chk("br1.pid", o_dataPid, 0);
        cyc();
        i_epValid = 4'b0110;
        tok(2);
        resp("br1.ep2", 0, 0);
        hs("br1.ep2", 0, 1, 0);
        tok(1);
        resp("br1.ep1", 0, 0);
        hs("br1.ep1", 1, 0, 4'b0010);
        tok(1);
        resp("rst1", 0, 1);
        i_rst = 1;
        hs("rst1", 1, 0, 0);
        @(negedge i_clk);
        chk("rst1.respValid", o_respValid, 0);
        chk("rst1.pid", o_dataPid, 0);
        cyc();
        tok(1);
        resp("rst1.ep1", 0, 0);
        hs("rst1.ep1", 0, 1, 0);

        // Randomized transactions against a transaction-level model; all toggles are 0 here.
        mtog = 0;
        for (int t = 0; t < 300; t++) begin
            int e, kind;
            bit [3:0] c;
            bit ack, to;
            int h;
            e = $urandom_range(0, 7);
            i_epValid = 4'($urandom);
            i_epStall = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            i_toggleClr = c;
            @(negedge i_clk);
            chk("rnd.idle", o_respValid, 0);
            cyc();
            mtog &= ~c;
            if (e >= NE || i_epStall[e]) kind = 2;
            else if (i_epValid[e]) kind = 0;
            else kind = 1;
            tok(e);
            resp("rnd", kind, (e < NE) ? int'(mtog[e]) : -1);
            if (kind == 0) begin
                i_epWrEn = 4'($urandom);
                i_epWrIdx = 12'($urandom);
                i_epWrByte = $urandom;
                i_txAccepted = 1'($urandom);
                @(negedge i_clk);
                chk("rnd.wrEn", o_wrEn, i_epWrEn[e]);
                chk("rnd.wrIdx", o_wrIdx, i_epWrIdx[e*IW +: IW]);
                chk("rnd.wrByte", o_wrByte, i_epWrByte[e*8 +: 8]);
                chk("rnd.txAcc", o_epTxAccepted, i_txAccepted ? (1 << e) : 0);
                chk("rnd.pid", o_dataPid, mtog[e]);
                cyc();
                h = $urandom_range(0, 2);
                ack = (h != 1);
                to = (h != 0);
                c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
                i_toggleClr = c;
                hs("rnd.hs", ack, to, ack ? (1 << e) : 0);
                if (ack) mtog[e] = ~mtog[e];
                mtog &= ~c;
            end else begin
                i_epWrEn = '1;
                @(negedge i_clk);
                chk("rnd.nodata_wrEn", o_wrEn, 0);
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
